// File: rtl/bus_timer_slave_pkg.sv
// Shared definitions for the bus timer slave: strobe polarities, bus
// direction codes, register indices, CTRL bit positions and FSM states.
package bus_timer_slave_pkg;

  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  localparam logic Read  = 1'b1;
  localparam logic Write = 1'b0;

  typedef enum logic [1:0] {
    TIMER_CTRL  = 2'd0,
    TIMER_INTR  = 2'd1,
    TIMER_EXPR  = 2'd2,
    TIMER_COUNT = 2'd3
  } reg_idx_t;

  localparam int START    = 0;
  localparam int PERIODIC = 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/bus_timer_slave_bus_slave_if.sv
// Bus handshake for one chip-select window: accepts a strobe in IDLE,
// issues a one-cycle active-low ready and registers the read data.
//
// state | meaning
// IDLE  | waiting for cs_ = 0 and as_ = 0; accepting here raises we/re
// ACK   | rdy_ low for this cycle only; any strobe seen is ignored
module bus_slave_if
  import bus_timer_slave_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [1:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              we,
  output logic              re,
  output reg_idx_t          reg_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_
);

  bus_state_t state;
  logic       accept;

  // An access is taken only from IDLE, which caps the rate at one per 2 cycles.
  always_comb begin
    accept = (state == IDLE) && (cs_ == Enable_) && (as_ == Enable_);
  end

  assign we      = accept && (rw == Write);
  assign re      = accept && (rw == Read);
  assign reg_idx = reg_idx_t'(reg_sel);

  // Handshake FSM; rd_data is captured at accept so it reflects pre-update values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdy_    <= Disable_;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= ACK;
            rdy_    <= Enable_;
            rd_data <= (rw == Read) ? reg_rdata : '0;
          end else begin
            rdy_    <= Disable_;
            rd_data <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          rdy_    <= Disable_;
          rd_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped 32-bit timer: CTRL/INTR/EXPR/COUNT behind a simple
// strobe/ready bus, with a registered level interrupt.
module bus_timer_slave
  import bus_timer_slave_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  output logic              irq
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic              we;
  logic              re;
  reg_idx_t          reg_idx;
  logic [DATA_W-1:0] reg_rdata;

  logic              start;
  logic              periodic;
  logic              intr_flag;
  logic [DATA_W-1:0] expr;
  logic [DATA_W-1:0] count;
  logic              match;

  // Upper address bits are decoded by the chip-select decoder, not here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:2];

  bus_slave_if #(.DATA_W(DATA_W)) u_bus_if (
    .clk       (clk),
    .reset     (reset),
    .cs_       (cs_),
    .as_       (as_),
    .rw        (rw),
    .reg_sel   (addr[1:0]),
    .reg_rdata (reg_rdata),
    .we        (we),
    .re        (re),
    .reg_idx   (reg_idx),
    .rd_data   (rd_data),
    .rdy_      (rdy_)
  );

  // Register read mux; only driven during an accepted read.
  always_comb begin
    reg_rdata = '0;
    if (re) begin
      case (reg_idx)
        TIMER_CTRL: begin
          reg_rdata[START]    = start;
          reg_rdata[PERIODIC] = periodic;
        end
        TIMER_INTR:  reg_rdata[0] = intr_flag;
        TIMER_EXPR:  reg_rdata    = expr;
        default:     reg_rdata    = count;
      endcase
    end
  end

  always_comb begin
    match = start && (count == expr);
  end

  // Timer and register updates; bus writes beat the timer except that an
  // expiry setting INTR beats a bus clear of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      start     <= 1'b0;
      periodic  <= 1'b0;
      intr_flag <= 1'b0;
      expr      <= '0;
      count     <= '0;
    end else begin
      if (we && reg_idx == TIMER_COUNT)
        count <= wr_data;
      else if (start)
        count <= match ? '0 : count + ONE;

      if (we && reg_idx == TIMER_CTRL) begin
        start    <= wr_data[START];
        periodic <= wr_data[PERIODIC];
      end else if (match && !periodic) begin
        start <= 1'b0;
      end

      if (match)
        intr_flag <= 1'b1;
      else if (we && reg_idx == TIMER_INTR && !wr_data[0])
        intr_flag <= 1'b0;

      if (we && reg_idx == TIMER_EXPR)
        expr <= wr_data;
    end
  end

  assign irq = intr_flag;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave: handshake, one-shot and periodic
// timing, collision priorities, isolation and reset.
module tb_bus_timer_slave;

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_INTR  = 2'd1;
  localparam logic [1:0] A_EXPR  = 2'd2;
  localparam logic [1:0] A_COUNT = 2'd3;

  logic        clk;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  int n_tests;
  int n_fail;

  logic [31:0] rv;

  bus_timer_slave #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs_     (cs_),
    .as_     (as_),
    .rw      (rw),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rdy_    (rdy_),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe in one cycle, check the acknowledge in the next, then release.
  task automatic do_write(input logic [1:0] idx, input logic [31:0] data);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = {28'd0, idx}; wr_data = data;
    @(negedge clk);
    check_val("wr_rdy", {31'd0, rdy_}, 32'd0);
    check_val("wr_rdata", rd_data, 32'd0);
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] idx, output logic [31:0] data);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = {28'd0, idx}; wr_data = 32'd0;
    @(negedge clk);
    check_val("rd_rdy", {31'd0, rdy_}, 32'd0);
    data = rd_data;
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_rdy", {31'd0, rdy_}, 32'd1);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_rdata", rd_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_read(i[1:0], rv);
      check_val("rst_reg", rv, 32'd0);
    end

    // Handshake
    do_write(A_EXPR, 32'h0000_0005);
    @(negedge clk);
    check_val("rdy_one_cycle", {31'd0, rdy_}, 32'd1);
    check_val("idle_rdata", rd_data, 32'd0);
    do_read(A_EXPR, rv);
    check_val("expr_rd", rv, 32'h5);

    // One-shot, irq timing: CTRL written in W, match in W+4, irq from W+5
    do_write(A_COUNT, 32'd0);
    do_write(A_EXPR, 32'd3);
    do_write(A_CTRL, 32'h1);
    check_val("os_irq_w1", {31'd0, irq}, 32'd0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check_val("os_irq_pre", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    check_val("os_irq_set", {31'd0, irq}, 32'd1);
    do_read(A_COUNT, rv);
    check_val("os_count_after", rv, 32'd0);
    do_read(A_CTRL, rv);
    check_val("os_ctrl_after", rv, 32'd0);

    // One-shot, count stepping sampled every 2 cycles
    do_write(A_INTR, 32'd0);
    check_val("intr_clr", {31'd0, irq}, 32'd0);
    do_write(A_CTRL, 32'h1);
    do_read(A_COUNT, rv);
    check_val("os_count_1", rv, 32'd1);
    do_read(A_COUNT, rv);
    check_val("os_count_3", rv, 32'd3);
    do_read(A_COUNT, rv);
    check_val("os_count_0", rv, 32'd0);
    check_val("os_irq2", {31'd0, irq}, 32'd1);

    // CTRL write on the match cycle keeps start set
    do_write(A_INTR, 32'd0);
    do_write(A_CTRL, 32'h1);
    do_write(A_EXPR, 32'd3);
    do_write(A_CTRL, 32'h1);
    do_read(A_CTRL, rv);
    check_val("ctrl_beats_clr", rv, 32'h1);
    do_read(A_COUNT, rv);
    check_val("ctrl_beats_cnt", rv, 32'd3);
    do_write(A_CTRL, 32'h0);

    // Periodic: EXPR 2, matches at W+3, W+6, W+9 ...
    do_write(A_INTR, 32'd0);
    do_write(A_COUNT, 32'd0);
    do_write(A_EXPR, 32'd2);
    do_write(A_CTRL, 32'h3);
    @(negedge clk);
    check_val("per_irq_w2", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check_val("per_irq_w3", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check_val("per_irq_w4", {31'd0, irq}, 32'd1);
    do_write(A_INTR, 32'd0);
    check_val("per_clr", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check_val("per_reexp", {31'd0, irq}, 32'd1);
    @(negedge clk);
    do_write(A_INTR, 32'd0);
    check_val("per_set_wins", {31'd0, irq}, 32'd1);
    do_read(A_COUNT, rv);
    check_val("per_count", rv, 32'd1);
    do_write(A_CTRL, 32'h0);
    do_write(A_INTR, 32'd0);

    // Collision: COUNT write during an increment
    do_write(A_COUNT, 32'd0);
    do_write(A_EXPR, 32'd10);
    do_write(A_CTRL, 32'h3);
    do_write(A_COUNT, 32'd7);
    do_read(A_COUNT, rv);
    check_val("coll_count", rv, 32'd8);
    do_write(A_CTRL, 32'h0);
    do_read(A_COUNT, rv);
    check_val("coll_stop_cnt", rv, 32'd0);
    check_val("coll_irq", {31'd0, irq}, 32'd1);
    do_write(A_INTR, 32'd0);

    // EXPR = 0 while running: matches every cycle
    do_write(A_EXPR, 32'd0);
    do_write(A_COUNT, 32'd0);
    do_write(A_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("e0_irq", {31'd0, irq}, 32'd1);
    end
    do_read(A_COUNT, rv);
    check_val("e0_count", rv, 32'd0);
    do_write(A_INTR, 32'd0);
    check_val("e0_clr_lost", {31'd0, irq}, 32'd1);
    do_write(A_CTRL, 32'h0);
    do_write(A_INTR, 32'd0);
    check_val("e0_clr_stop", {31'd0, irq}, 32'd0);

    // Isolation: strobes with cs_ high
    do_write(A_EXPR, 32'h0000_1234);
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b0; rw = 1'b0; wr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      addr = 30'(i % 4);
      @(negedge clk);
      check_val("iso_rdy", {31'd0, rdy_}, 32'd1);
    end
    as_ = 1'b1;
    do_read(A_EXPR, rv);
    check_val("iso_expr", rv, 32'h0000_1234);
    do_read(A_CTRL, rv);
    check_val("iso_ctrl", rv, 32'd0);
    do_read(A_COUNT, rv);
    check_val("iso_count", rv, 32'd0);
    do_read(A_INTR, rv);
    check_val("iso_intr", rv, 32'd0);

    // Strobes held low: ready on every other cycle
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = {28'd0, A_EXPR};
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_val("b2b_rdy", {31'd0, rdy_}, (i % 2 == 1) ? 32'd0 : 32'd1);
      check_val("b2b_rdata", rd_data, (i % 2 == 1) ? 32'h0000_1234 : 32'd0);
    end
    cs_ = 1'b1; as_ = 1'b1;

    // Reset asserted during an acknowledge
    do_write(A_COUNT, 32'd9);
    do_write(A_CTRL, 32'h2);
    @(negedge clk);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = {28'd0, A_EXPR}; wr_data = 32'h55;
    @(negedge clk);
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1;
    @(negedge clk);
    check_val("mid_rst_rdy", {31'd0, rdy_}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_irq", {31'd0, irq}, 32'd0);
    check_val("mid_rst_rdata", rd_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_read(i[1:0], rv);
      check_val("mid_rst_reg", rv, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer_slave.md
Name: bus_timer_slave

Overview:
- Memory-mapped bus responder for one address-decoder chip-select window. It is the slave end of the shared bus that the chip-select decoder fronts.
- Contains a free-running 32-bit timer with four word registers:
  - CTRL: start and periodic bits.
  - INTR: sticky irq flag.
  - EXPR: expiry value.
  - COUNT: current count.
- Answers each accepted read or write with a one-cycle active-low ready pulse.
- Drives a level interrupt to the interrupt controller.

Parameters:
- ADDR_W, 30, bus word-address width. Only addr[1:0] is decoded here; upper bits belong to the chip-select decoder.
- DATA_W, 32, bus data width and timer width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cs_  in  1  active-low chip select from the address decoder.
- as_  in  1  active-low address strobe, one per access.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_W  word address; addr[1:0] selects the register.
- wr_data  in  DATA_W  write data, valid with as_.
- rd_data  out  DATA_W  read data, valid only while rdy_ = 0.
- rdy_  out  1  active-low acknowledge.
- irq  out  1  active-high interrupt, equal to INTR[0].

Behaviour:
- Reset:
  - Clock and reset: single clock clk; reset is synchronous and active-high.
  - When reset = 1 at a clk edge, all of the following clear: CTRL, INTR, EXPR, COUNT, rd_data, irq; rdy_ = 1; FSM = IDLE.
  - Reset in ACK aborts the pending ready: no rdy_ pulse is issued.
- FSM states: IDLE and ACK.
  - IDLE -> ACK when cs_ = 0 and as_ = 0 in cycle N (the access is accepted).
  - ACK -> IDLE unconditionally.
  - Strobes seen while in ACK are ignored. Maximum rate is one access per 2 cycles; the master must drop as_ or re-present the access.
- Latency:
  - Accept in cycle N; rdy_ = 0 only in cycle N+1.
  - Read: rd_data in N+1 is the register value sampled in cycle N, before any timer update in N.
  - Write: the register is updated at the end of cycle N, so the new value is visible from N+1. rd_data = 0 during a write acknowledge.
  - rd_data = 0 whenever rdy_ = 1.
- Register map (addr[1:0]):
  - 0 CTRL: bit0 = start, bit1 = periodic; other bits read 0.
  - 1 INTR: bit0 = irq flag. Writing 0 to bit0 clears it; writing 1 has no effect. Other bits read 0.
  - 2 EXPR: full width.
  - 3 COUNT: full width.
- Timer, evaluated each cycle while start = 1:
  - If COUNT == EXPR: COUNT <= 0, INTR[0] <= 1, and start <= 0 if periodic = 0.
  - Otherwise COUNT <= COUNT + 1, with modulo 2^DATA_W wrap.
  - When start = 0, COUNT holds.
- Simultaneous-event priorities:
  - Bus write to COUNT vs. timer update: the bus write wins.
  - Bus write to CTRL vs. one-shot auto-clear of start: the bus write wins.
  - Bus clear of INTR vs. expiry in the same cycle: set wins, so INTR[0] = 1.
  - EXPR = 0 with start = 1: matches every cycle, so irq stays 1 and COUNT stays 0.
- irq is the registered INTR[0]; there is no combinational path from the bus.
- cs_ = 1 with as_ = 0 is another slave's access: no state change, rdy_ stays 1.

Decomposition:
- Shared definitions package (define header), holding:
  - Enable_ = 0 and Disable_ = 1 for active-low strobes.
  - Read = 1 and Write = 0.
  - Register indices TIMER_CTRL = 0, TIMER_INTR = 1, TIMER_EXPR = 2, TIMER_COUNT = 3.
  - CTRL bit positions START = 0, PERIODIC = 1.
  - FSM state encodings.
- One natural sub-module, bus_slave_if. It holds the IDLE/ACK FSM, rdy_ and rd_data registers, and generates a single-cycle we/re strobe plus register index. The timer core instantiates it.

Test Plan:
- Reset: assert reset for 2 cycles mid-ACK -> rdy_ = 1, irq = 0, and reads of all four registers return 0.
- Write/read handshake:
  - Write EXPR = 0x0000_0005 (cs_ = 0, as_ = 0, rw = 0) -> rdy_ = 0 exactly one cycle later, rd_data = 0.
  - Read addr 2 -> rdy_ pulse, rd_data = 0x5.
- One-shot timer: EXPR = 3, CTRL = 0x1 -> COUNT steps 0,1,2,3,0. irq rises the cycle after the match; CTRL then reads 0x0 and COUNT stays 0.
- Periodic timer: EXPR = 2, CTRL = 0x3 -> expiries every 3 cycles.
  - Write INTR = 0 -> irq drops.
  - Repeat the clear timed on the expiry cycle -> irq stays 1.
- Collision: while running with EXPR = 10, write COUNT = 7 in the same cycle as an increment -> next read returns 7 or 8 as dictated by elapsed cycles, never the incremented old value.
- Isolation: as_ = 0 with cs_ = 1 for 5 cycles, including a write attempt -> rdy_ stays 1 and no register changes. Back-to-back strobes held low -> one acknowledge per 2 cycles.
